// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and the pixel/SRAM-address stage (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic        pix_en;
  logic        h_sync;
  logic        v_sync;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        display_en;
  logic        line_start;
  logic        frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0]  frame_cnt;

  modport master (input pix_en, output h_sync, v_sync, h_count, v_count,
                  display_en, line_start, frame_start, frame_cnt);
  modport slave  (output pix_en, input h_sync, v_sync, h_count, v_count,
                  display_en, line_start, frame_start, frame_cnt);
`else
  modport master (input pix_en, output h_sync, v_sync, h_count, v_count,
                  display_en, line_start, frame_start);
  modport slave  (output pix_en, input h_sync, v_sync, h_count, v_count,
                  display_en, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, syncs, display window and strobes, all registered per pixel.
// Optional VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input logic             clk_in,
  input logic             reset,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_cfg_err
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end
  endgenerate

  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_FRONT  = 3'd2;
  localparam logic [2:0] S_SYNC   = 3'd3;
  localparam logic [2:0] S_BACK   = 3'd4;

  logic [2:0]  st_q, st_d;
  logic [11:0] h_q, v_q, h_d, v_d;
  logic        hs_q, vs_q, de_q, ls_q, fs_q;

  // Next-pixel computation; the state names the region of the pixel being presented.
  always_comb begin
    st_d = st_q;
    h_d  = h_q;
    v_d  = v_q;
    if (st_q == S_IDLE) begin
      st_d = S_ACTIVE;
      h_d  = '0;
      v_d  = '0;
    end else begin
      h_d = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
      if (h_q == H_LAST)
        v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      case (st_q)
        S_ACTIVE: if (h_q == H_ACT_END)  st_d = S_FRONT;
        S_FRONT:  if (h_q == H_FP_END)   st_d = S_SYNC;
        S_SYNC:   if (h_q == H_SYNC_END) st_d = S_BACK;
        S_BACK:   if (h_q == H_LAST)     st_d = S_ACTIVE;
        default:                         st_d = S_IDLE;
      endcase
    end
  end

  // Flags are derived from the next pixel so they register alongside the counts.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (vif.pix_en) begin
      st_q <= st_d;
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= (st_d == S_SYNC) ? H_POL : ~H_POL;
      vs_q <= (v_d >= V_SYNC_BEG && v_d <= V_SYNC_END) ? V_POL : ~V_POL;
      de_q <= (st_d == S_ACTIVE) && (v_d < V_ACT);
      ls_q <= (h_d == 12'd0);
      fs_q <= (h_d == 12'd0) && (v_d == 12'd0);
    end
  end

  assign vif.h_count     = h_q;
  assign vif.v_count     = v_q;
  assign vif.h_sync      = hs_q;
  assign vif.v_sync      = vs_q;
  assign vif.display_en  = de_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  // The IDLE->(0,0) edge opens frame 0, so only wraps back to (0,0) count.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)
      fcnt_q <= '0;
    else if (vif.pix_en && st_q != S_IDLE && h_d == 12'd0 && v_d == 12'd0)
      fcnt_q <= fcnt_q + 8'd1;
  end

  assign vif.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-geometry DUT plus a tiny-geometry DUT for whole-frame behaviour.
module tb_vga_timing_gen;
  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic pix_en = 1'b0;
  int   n      = -1;  // pix_en edges since reset release; -1 = reset state
  int   tests  = 0;
  int   fails  = 0;

  always #5 clk_in = ~clk_in;

  vga_timing_gen_if vd ();
  vga_timing_gen_if vsm ();
  assign vd.pix_en  = pix_en;
  assign vsm.pix_en = pix_en;

  vga_timing_gen u_def (.clk_in(clk_in), .reset(reset), .vif(vd));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_small (.clk_in(clk_in), .reset(reset), .vif(vsm));

  always @(posedge clk_in or negedge reset)
    if (!reset) n <= -1;
    else if (pix_en) n <= n + 1;

  typedef struct packed {
    logic        hs, vs;
    logic [11:0] h, v;
    logic        de, ls, fs;
    logic [7:0]  fc;
  } out_t;

  // Reference: pixel index since restart mapped to raster coordinates.
  function automatic out_t model(int k, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit hp, bit vp);
    out_t o;
    int ht, vt, p, h, v;
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    if (k < 0) return o;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = k % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    o.h  = 12'(h);
    o.v  = 12'(v);
    o.de = (h < ha) && (v < va);
    o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    o.ls = (h == 0);
    o.fs = (p == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 8'((k / (ht * vt)) % 256);
`endif
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d",
                     o.h, o.v, o.hs, o.vs, o.de, o.ls, o.fs, o.fc);
  endfunction

  task automatic cmp(string tag, out_t a, out_t e);
    tests++;
    if (a !== e) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s n=%0d got {%s} exp {%s}", tag, n, fmt(a), fmt(e));
    end
  endtask

  task automatic check_all(string tag);
    out_t ad, as_;
    ad  = '0;
    as_ = '0;
    ad.hs = vd.h_sync;  ad.vs = vd.v_sync;  ad.h = vd.h_count;  ad.v = vd.v_count;
    ad.de = vd.display_en;  ad.ls = vd.line_start;  ad.fs = vd.frame_start;
    as_.hs = vsm.h_sync; as_.vs = vsm.v_sync; as_.h = vsm.h_count; as_.v = vsm.v_count;
    as_.de = vsm.display_en; as_.ls = vsm.line_start; as_.fs = vsm.frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    ad.fc  = vd.frame_cnt;
    as_.fc = vsm.frame_cnt;
`endif
    cmp({tag, "_def"}, ad, model(n, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1));
    cmp({tag, "_small"}, as_, model(n, 8, 2, 3, 2, 4, 2, 1, 2, 1'b0, 1'b0));
  endtask

  typedef struct {
    bit rst_n, pe;
    int h, v;
    bit de, ls, fs, hs;
  } vec_t;

  task automatic restart();
    @(negedge clk_in);
    reset  = 1'b0;
    pix_en = 1'b0;
    @(negedge clk_in);
    reset  = 1'b1;
    pix_en = 1'b1;
  endtask

  initial begin
    vec_t vecs[8];
    int   de_cnt, hs_cnt;
    vecs[0] = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 0, 0, 1, 1, 1, 0};
    vecs[3] = '{1, 1, 1, 0, 1, 0, 0, 0};
    vecs[4] = '{1, 0, 1, 0, 1, 0, 0, 0};
    vecs[5] = '{1, 1, 2, 0, 1, 0, 0, 0};
    vecs[6] = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{1, 1, 0, 0, 1, 1, 1, 0};

    @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      reset  = vecs[i].rst_n;
      pix_en = vecs[i].pe;
      @(negedge clk_in);
      tests++;
      if (vd.h_count !== 12'(vecs[i].h) || vd.v_count !== 12'(vecs[i].v) ||
          vd.display_en !== vecs[i].de || vd.line_start !== vecs[i].ls ||
          vd.frame_start !== vecs[i].fs || vd.h_sync !== vecs[i].hs) begin
        fails++;
        $display("FAIL vec%0d got h=%0d v=%0d de=%0b ls=%0b fs=%0b hs=%0b exp h=%0d v=%0d de=%0b ls=%0b fs=%0b hs=%0b",
                 i, vd.h_count, vd.v_count, vd.display_en, vd.line_start, vd.frame_start,
                 vd.h_sync, vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].ls, vecs[i].fs, vecs[i].hs);
      end
    end

    // First two lines at default geometry, continuous pix_en.
    restart();
    de_cnt = 0;
    hs_cnt = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk_in);
      check_all("line");
      if (vd.v_count == 12'd0) begin
        if (vd.display_en) de_cnt++;
        if (vd.h_sync) hs_cnt++;
      end
    end
    tests++;
    if (de_cnt != 800) begin
      fails++;
      $display("FAIL line0_de_width got %0d exp 800", de_cnt);
    end
    tests++;
    if (hs_cnt != 120) begin
      fails++;
      $display("FAIL line0_hsync_width got %0d exp 120", hs_cnt);
    end

    // Alternating pix_en: strobes span two clk_in cycles.
    restart();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_in);
      check_all("alt");
      pix_en = ~pix_en;
    end

    // Random pix_en with occasional reset pulses between clock edges.
    restart();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_in);
      check_all("rand");
      pix_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk_in);
        reset = 1'b1;
      end
    end

    // 257 small frames: frame_start period and frame counter wrap.
    restart();
    for (int i = 0; i < 135 * 257 + 5; i++) begin
      @(negedge clk_in);
      check_all("frames");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
